// File: rtl/seg_disp_arb.sv
// Round-robin arbiter that time-shares one 4-digit 7-segment display among NREQ requesters,
// holding each owner for at least MIN_TICKS and pre-empting it after MAX_TICKS if others wait.
module seg_disp_arb #(
  parameter int          NREQ       = 3,
  parameter int          CLK_DIV    = 50000,
  parameter int          MIN_TICKS  = 500,
  parameter int          MAX_TICKS  = 2000,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [16*NREQ-1:0] data_in,
  output logic [15:0]        number,
  output logic [NREQ-1:0]    grant,
  output logic [1:0]         owner,
  output logic               busy
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int DW = $clog2(MAX_TICKS + 1);
  localparam logic [DW-1:0] MIN_D = DW'(MIN_TICKS);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_TICKS);

  typedef enum logic [1:0] {IDLE, HOLD, ARB} state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc;
  logic          tick;
  logic [DW-1:0] dwell;
  logic [1:0]    last;
  logic [1:0]    win;
  logic          own_req;
  logic          others;
  logic          hold_exit;
  int            idx;

  assign tick = (presc == PW'(CLK_DIV - 1));

  // Round-robin search starting just after the previous owner, wrapping modulo NREQ.
  always_comb begin
    win = last;
    idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) win = 2'(idx);
    end
  end

  always_comb begin
    own_req    = req[owner];
    others     = |(req & ~grant);
    hold_exit  = (!own_req && dwell >= MIN_D) || (dwell >= MAX_D && others);
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = HOLD;
      HOLD:    if (hold_exit) state_next = ARB;
      ARB:     state_next = (|req) ? HOLD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      presc  <= '0;
      dwell  <= '0;
      last   <= 2'(NREQ - 1);
      number <= IDLE_VALUE;
      grant  <= '0;
      owner  <= '0;
      busy   <= 1'b0;
    end else begin
      state <= state_next;
      presc <= tick ? '0 : presc + 1'b1;
      case (state)
        IDLE, ARB: begin
          if (|req) begin
            grant      <= '0;
            grant[win] <= 1'b1;
            owner      <= win;
            last       <= win;
            busy       <= 1'b1;
            dwell      <= '0;
          end else begin
            grant  <= '0;
            busy   <= 1'b0;
            number <= IDLE_VALUE;
          end
        end
        HOLD: begin
          // The shown value freezes whenever the owner lets go of its request line.
          if (own_req) number <= data_in[{owner, 4'b0000} +: 16];
          if (hold_exit) begin
            grant <= '0;
            busy  <= 1'b0;
          end else if (tick && dwell < MAX_D) begin
            dwell <= dwell + 1'b1;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_arb.sv
// Directed self-checking bench for seg_disp_arb with CLK_DIV=4, MIN_TICKS=2, MAX_TICKS=5.
module tb_seg_disp_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [47:0] data_in = '0;
  logic [15:0] number;
  logic [2:0]  grant;
  logic [1:0]  owner;
  logic        busy;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  seg_disp_arb #(
    .NREQ(3), .CLK_DIV(4), .MIN_TICKS(2), .MAX_TICKS(5), .IDLE_VALUE(16'hFFFF)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .number(number), .grant(grant), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2);
    req     = r;
    data_in = {d2, d1, d0};
  endtask

  // Edges are counted from the first edge after reset release; the prescaler ticks on every 4th.
  task automatic tickTo(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_grant", 16'(grant), 16'h0000);
    checkOutput("rst_number", number, 16'hFFFF);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    $display("[TB] test 1: reset");
    applyStimulus(3'b111, 16'h1111, 16'h2222, 16'h3333);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t1_rst_grant", 16'(grant), 16'h0000);
      checkOutput("t1_rst_busy", 16'(busy), 16'h0000);
      checkOutput("t1_rst_number", number, 16'hFFFF);
    end
    rst = 1'b0;
    cyc = 0;
    tickTo(1);
    checkOutput("t1_grant", 16'(grant), 16'h0001);
    checkOutput("t1_busy", 16'(busy), 16'h0001);
    checkOutput("t1_owner", 16'(owner), 16'h0000);
    tickTo(2);
    checkOutput("t1_number", number, 16'h1111);

    $display("[TB] test 2: single request");
    applyStimulus(3'b000, 16'h0000, 16'h0000, 16'h0000);
    applyReset();
    applyStimulus(3'b010, 16'h0000, 16'h1234, 16'h0000);
    tickTo(1);
    checkOutput("t2_grant", 16'(grant), 16'h0002);
    checkOutput("t2_owner", 16'(owner), 16'h0001);
    checkOutput("t2_number_idle", number, 16'hFFFF);
    tickTo(2);
    checkOutput("t2_number", number, 16'h1234);
    applyStimulus(3'b010, 16'h0000, 16'hABCD, 16'h0000);
    tickTo(3);
    checkOutput("t2_number_follow", number, 16'hABCD);

    $display("[TB] test 3: minimum dwell");
    applyStimulus(3'b000, 16'h0000, 16'h0000, 16'h0000);
    applyReset();
    applyStimulus(3'b001, 16'h0042, 16'h0000, 16'h0000);
    tickTo(1);
    checkOutput("t3_grant", 16'(grant), 16'h0001);
    tickTo(4);
    checkOutput("t3_number", number, 16'h0042);
    applyStimulus(3'b000, 16'h0099, 16'h0000, 16'h0000);
    tickTo(8);
    checkOutput("t3_hold_grant", 16'(grant), 16'h0001);
    checkOutput("t3_hold_number", number, 16'h0042);
    tickTo(9);
    checkOutput("t3_arb_grant", 16'(grant), 16'h0000);
    checkOutput("t3_arb_busy", 16'(busy), 16'h0000);
    checkOutput("t3_arb_number", number, 16'h0042);
    tickTo(10);
    checkOutput("t3_idle_number", number, 16'hFFFF);
    checkOutput("t3_idle_grant", 16'(grant), 16'h0000);

    $display("[TB] test 4: maximum dwell");
    applyStimulus(3'b000, 16'h0000, 16'h0000, 16'h0000);
    applyReset();
    applyStimulus(3'b101, 16'h0A0A, 16'h0000, 16'h0C0C);
    tickTo(1);
    checkOutput("t4_grant0", 16'(grant), 16'h0001);
    tickTo(20);
    checkOutput("t4_grant0_late", 16'(grant), 16'h0001);
    tickTo(21);
    checkOutput("t4_gap1", 16'(grant), 16'h0000);
    tickTo(22);
    checkOutput("t4_grant2", 16'(grant), 16'h0004);
    checkOutput("t4_owner2", 16'(owner), 16'h0002);
    tickTo(23);
    checkOutput("t4_number2", number, 16'h0C0C);
    tickTo(40);
    checkOutput("t4_grant2_late", 16'(grant), 16'h0004);
    tickTo(41);
    checkOutput("t4_gap2", 16'(grant), 16'h0000);
    tickTo(42);
    checkOutput("t4_grant0_again", 16'(grant), 16'h0001);

    $display("[TB] test 5: round-robin fairness");
    applyStimulus(3'b000, 16'h0000, 16'h0000, 16'h0000);
    applyReset();
    applyStimulus(3'b111, 16'h5550, 16'h5551, 16'h5552);
    tickTo(1);
    checkOutput("t5_g001", 16'(grant), 16'h0001);
    tickTo(21);
    checkOutput("t5_gap_a", 16'(grant), 16'h0000);
    tickTo(22);
    checkOutput("t5_g010", 16'(grant), 16'h0002);
    tickTo(23);
    checkOutput("t5_number1", number, 16'h5551);
    tickTo(41);
    checkOutput("t5_gap_b", 16'(grant), 16'h0000);
    tickTo(42);
    checkOutput("t5_g100", 16'(grant), 16'h0004);
    tickTo(61);
    checkOutput("t5_gap_c", 16'(grant), 16'h0000);
    tickTo(62);
    checkOutput("t5_g001_again", 16'(grant), 16'h0001);

    $display("[TB] test 6: reset mid-operation");
    applyStimulus(3'b000, 16'h0000, 16'h0000, 16'h0000);
    applyReset();
    applyStimulus(3'b111, 16'h6660, 16'h6661, 16'h6662);
    tickTo(45);
    checkOutput("t6_owner2", 16'(owner), 16'h0002);
    checkOutput("t6_grant2", 16'(grant), 16'h0004);
    checkOutput("t6_number2", number, 16'h6662);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_rst_grant", 16'(grant), 16'h0000);
    checkOutput("t6_rst_number", number, 16'hFFFF);
    checkOutput("t6_rst_busy", 16'(busy), 16'h0000);
    rst = 1'b0;
    cyc = 0;
    tickTo(1);
    checkOutput("t6_grant_after", 16'(grant), 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
